// File: rtl/ndn_iface_endpoint_if.sv
// Byte-stream handshake bundle between the link endpoint and its local user.
// The endpoint drives the RX pop side and the TX push side through the slave modport.
interface ndn_iface_endpoint_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport slave (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  rx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport master (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output rx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/ndn_iface_endpoint.sv
// Interface-side peer of the router's serial link: frames on mosi are deserialised
// into an RX FIFO, bytes from a TX FIFO are framed onto a registered miso.
module ndn_iface_endpoint #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 rx_overflow,
    ndn_iface_endpoint_if.slave  link
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_GAP   = 2'd3
    } tx_state_t;

    rx_state_t   rx_state_q, rx_state_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_done_s;

    logic [7:0]  rx_mem_q [FIFO_DEPTH];
    logic [AW:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic        rx_empty_s, rx_full_s, rx_pop_s, rx_push_s, rx_drop_s;
    logic        rx_overflow_q;

    tx_state_t   tx_state_q, tx_state_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        miso_q, miso_d;

    logic [7:0]  tx_mem_q [FIFO_DEPTH];
    logic [AW:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic        tx_empty_s, tx_full_s, tx_pop_s, tx_push_s;
    logic [7:0]  tx_head_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign rx_empty_s = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_full_s  = (rx_wr_ptr_q[AW] != rx_rd_ptr_q[AW]) &&
                        (rx_wr_ptr_q[AW-1:0] == rx_rd_ptr_q[AW-1:0]);
    assign tx_empty_s = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign tx_full_s  = (tx_wr_ptr_q[AW] != tx_rd_ptr_q[AW]) &&
                        (tx_wr_ptr_q[AW-1:0] == tx_rd_ptr_q[AW-1:0]);

    assign rx_pop_s  = !rx_empty_s && link.rx_ready;
    assign rx_push_s = rx_done_s && (!rx_full_s || rx_pop_s);
    assign rx_drop_s = rx_done_s && rx_full_s && !rx_pop_s;

    assign link.tx_ready = !tx_full_s && !rst;
    assign tx_push_s     = link.tx_valid && !tx_full_s && !rst;
    assign tx_head_s     = tx_mem_q[tx_rd_ptr_q[AW-1:0]];

    assign miso        = miso_q;
    assign rx_overflow = rx_overflow_q;

    // First-word fall-through view of the RX FIFO head, forced to zero when empty.
    always_comb begin
        link.rx_valid = 1'b0;
        link.rx_data  = 8'h00;
        if (!rx_empty_s) begin
            link.rx_valid = 1'b1;
            link.rx_data  = rx_mem_q[rx_rd_ptr_q[AW-1:0]];
        end else begin
            link.rx_valid = 1'b0;
            link.rx_data  = 8'h00;
        end
    end

    // RX framing: wait for a start bit, then shift eight data bits MSB first.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_done_s  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (mosi) begin
                    rx_state_d = R_DATA;
                    rx_cnt_d   = 3'd0;
                end else begin
                    rx_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                rx_shift_d = {rx_shift_q[6:0], mosi};
                rx_cnt_d   = rx_cnt_q + 3'd1;
                if (rx_cnt_q == 3'd7) begin
                    rx_done_s  = 1'b1;
                    rx_state_d = R_IDLE;
                end else begin
                    rx_state_d = R_DATA;
                end
            end
            default: begin
                rx_state_d = R_IDLE;
            end
        endcase
    end

    // TX framing; miso_d reflects the current state so miso lags the FSM by one edge.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_shift_d = tx_shift_q;
        miso_d     = 1'b0;
        tx_pop_s   = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_d = tx_head_s;
                    tx_state_d = T_START;
                end else begin
                    tx_state_d = T_IDLE;
                end
            end
            T_START: begin
                miso_d     = 1'b1;
                tx_cnt_d   = 3'd0;
                tx_state_d = T_DATA;
            end
            T_DATA: begin
                miso_d     = tx_shift_q[7];
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
                tx_cnt_d   = tx_cnt_q + 3'd1;
                if (tx_cnt_q == 3'd7) begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d  = 4'd0;
                        tx_state_d = T_GAP;
                    end else if (!tx_empty_s) begin
                        // Chain straight into the next start bit with no idle cycle.
                        tx_pop_s   = 1'b1;
                        tx_shift_d = tx_head_s;
                        tx_state_d = T_START;
                    end else begin
                        tx_state_d = T_IDLE;
                    end
                end else begin
                    tx_state_d = T_DATA;
                end
            end
            T_GAP: begin
                miso_d    = 1'b0;
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == GAP_LAST) begin
                    if (!tx_empty_s) begin
                        tx_pop_s   = 1'b1;
                        tx_shift_d = tx_head_s;
                        tx_state_d = T_START;
                    end else begin
                        tx_state_d = T_IDLE;
                    end
                end else begin
                    tx_state_d = T_GAP;
                end
            end
            default: begin
                tx_state_d = T_IDLE;
            end
        endcase
    end

    // RX state, FIFO storage and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= R_IDLE;
            rx_cnt_q      <= 3'd0;
            rx_shift_q    <= 8'h00;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem_q[i] <= 8'h00;
            end
        end else begin
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_overflow_q <= rx_overflow_q | rx_drop_s;
            if (rx_push_s) begin
                rx_mem_q[rx_wr_ptr_q[AW-1:0]] <= rx_shift_d;
                rx_wr_ptr_q <= rx_wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (rx_pop_s) begin
                rx_rd_ptr_q <= rx_rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // TX state, FIFO storage and the registered miso driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= T_IDLE;
            tx_cnt_q    <= 3'd0;
            gap_cnt_q   <= 4'd0;
            tx_shift_q  <= 8'h00;
            miso_q      <= 1'b0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_q[i] <= 8'h00;
            end
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_shift_q <= tx_shift_d;
            miso_q     <= miso_d;
            if (tx_push_s) begin
                tx_mem_q[tx_wr_ptr_q[AW-1:0]] <= link.tx_data;
                tx_wr_ptr_q <= tx_wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (tx_pop_s) begin
                tx_rd_ptr_q <= tx_rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_ndn_iface_endpoint.sv
// Directed bench for ndn_iface_endpoint: one instance with a 1-cycle TX gap,
// one with no gap for back-to-back framing.
module tb_ndn_iface_endpoint;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mosi1, miso1, ovf1;
    logic mosi0, miso0, ovf0;

    ndn_iface_endpoint_if l1();
    ndn_iface_endpoint_if l0();

    ndn_iface_endpoint #(.FIFO_DEPTH(4), .GAP_CYCLES(1)) dut_g1 (
        .clk(clk), .rst(rst), .mosi(mosi1), .miso(miso1),
        .rx_overflow(ovf1), .link(l1)
    );

    ndn_iface_endpoint #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst(rst), .mosi(mosi0), .miso(miso0),
        .rx_overflow(ovf0), .link(l0)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        mosi1 = b;
        @(negedge clk);
    endtask

    // Start bit plus eight data bits; optionally pop the RX head during the last bit.
    task automatic send_frame(input logic [7:0] v, input logic pop_last);
        send_bit(1'b1);
        for (int i = 7; i >= 1; i--) begin
            send_bit(v[i]);
        end
        l1.rx_ready = pop_last;
        send_bit(v[0]);
        l1.rx_ready = 1'b0;
        mosi1 = 1'b0;
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, {31'd0, l1.rx_valid}, 32'd1);
        chk(tag, {24'd0, l1.rx_data}, {24'd0, exp});
        l1.rx_ready = 1'b1;
        @(negedge clk);
        l1.rx_ready = 1'b0;
    endtask

    initial begin
        logic [8:0]  rx_bits;
        logic [11:0] tx_exp;
        logic [28:0] b2b_exp;

        rst = 1'b1;
        mosi1 = 1'b0;
        mosi0 = 1'b0;
        l1.rx_ready = 1'b0; l1.tx_valid = 1'b0; l1.tx_data = 8'h00;
        l0.rx_ready = 1'b0; l0.tx_valid = 1'b0; l0.tx_data = 8'h00;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_miso", {31'd0, miso1}, 32'd0);
        chk("rst_rx_valid", {31'd0, l1.rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, l1.rx_data}, 32'd0);
        chk("rst_ovf", {31'd0, ovf1}, 32'd0);
        chk("rst_tx_ready_g1", {31'd0, l1.tx_ready}, 32'd0);
        chk("rst_tx_ready_g0", {31'd0, l0.tx_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_tx_ready_g1", {31'd0, l1.tx_ready}, 32'd1);
        chk("post_rst_tx_ready_g0", {31'd0, l0.tx_ready}, 32'd1);
        @(negedge clk);

        // RX decode of 0xA5
        rx_bits = 9'b1_1010_0101;
        for (int i = 8; i >= 0; i--) begin
            send_bit(rx_bits[i]);
        end
        mosi1 = 1'b0;
        chk("rxA5_valid", {31'd0, l1.rx_valid}, 32'd1);
        chk("rxA5_data", {24'd0, l1.rx_data}, 32'h0000_00A5);
        l1.rx_ready = 1'b1;
        @(negedge clk);
        l1.rx_ready = 1'b0;
        chk("rxA5_popped_valid", {31'd0, l1.rx_valid}, 32'd0);
        chk("rxA5_popped_data", {24'd0, l1.rx_data}, 32'd0);

        // TX encode of 0x3C with a 1-cycle gap
        l1.tx_data  = 8'h3C;
        l1.tx_valid = 1'b1;
        chk("tx3C_ready", {31'd0, l1.tx_ready}, 32'd1);
        @(negedge clk);
        l1.tx_valid = 1'b0;
        chk("tx3C_lat_n", {31'd0, miso1}, 32'd0);
        @(negedge clk);
        chk("tx3C_lat_n1", {31'd0, miso1}, 32'd0);
        @(negedge clk);
        tx_exp = 12'b1_0011_1100_000;
        for (int i = 11; i >= 0; i--) begin
            chk($sformatf("tx3C_bit%0d", 11 - i), {31'd0, miso1}, {31'd0, tx_exp[i]});
            @(negedge clk);
        end

        // Full RX FIFO with a simultaneous pop accepts the incoming byte
        send_frame(8'h11, 1'b0);
        send_frame(8'h12, 1'b0);
        send_frame(8'h13, 1'b0);
        send_frame(8'h14, 1'b0);
        chk("full_ovf_before", {31'd0, ovf1}, 32'd0);
        send_frame(8'h15, 1'b1);
        chk("full_pop_ovf", {31'd0, ovf1}, 32'd0);
        pop_rx("full_pop_12", 8'h12);
        pop_rx("full_pop_13", 8'h13);
        pop_rx("full_pop_14", 8'h14);
        pop_rx("full_pop_15", 8'h15);
        chk("full_pop_empty", {31'd0, l1.rx_valid}, 32'd0);

        // RX overflow: five frames, no pops
        for (int f = 1; f <= 4; f++) begin
            send_frame(8'(f), 1'b0);
        end
        chk("ovf_after4", {31'd0, ovf1}, 32'd0);
        send_frame(8'h05, 1'b0);
        chk("ovf_set", {31'd0, ovf1}, 32'd1);
        pop_rx("ovf_pop_01", 8'h01);
        pop_rx("ovf_pop_02", 8'h02);
        pop_rx("ovf_pop_03", 8'h03);
        pop_rx("ovf_pop_04", 8'h04);
        chk("ovf_empty", {31'd0, l1.rx_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf1}, 32'd1);

        // Reset in the middle of an RX frame; mosi held high during reset is ignored
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
        end
        rst = 1'b1;
        mosi1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mosi1 = 1'b0;
        chk("midrst_ovf", {31'd0, ovf1}, 32'd0);
        chk("midrst_valid", {31'd0, l1.rx_valid}, 32'd0);
        chk("midrst_miso", {31'd0, miso1}, 32'd0);
        send_bit(1'b0);
        chk("midrst_idle_valid", {31'd0, l1.rx_valid}, 32'd0);
        send_frame(8'h5A, 1'b0);
        pop_rx("midrst_5A", 8'h5A);
        chk("midrst_only_one", {31'd0, l1.rx_valid}, 32'd0);

        // Back-to-back TX with no gap
        l0.tx_data  = 8'h80;
        l0.tx_valid = 1'b1;
        @(negedge clk);
        l0.tx_data  = 8'h01;
        @(negedge clk);
        l0.tx_data  = 8'hFF;
        @(negedge clk);
        l0.tx_valid = 1'b0;
        b2b_exp = {1'b1, 8'h80, 1'b1, 8'h01, 1'b1, 8'hFF, 2'b00};
        for (int i = 28; i >= 0; i--) begin
            chk($sformatf("b2b_bit%0d", 28 - i), {31'd0, miso0}, {31'd0, b2b_exp[i]});
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
